// File: rtl/bus_pkg.sv
// Shared types and defaults for the data-memory bus demux.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } demux_state_t;

    typedef logic tgt_sel_t;
    localparam tgt_sel_t TGT_RAM  = 1'b0;
    localparam tgt_sel_t TGT_MMIO = 1'b1;

    localparam logic [31:0] DEF_MMIO_BASE = 32'h1000_0000;
    localparam logic [31:0] DEF_MMIO_MASK = 32'hF000_0000;

    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] tmo_cnt_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Address to target select, plus word-misalignment flag.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] MMIO_BASE = WIDTH'(DEF_MMIO_BASE),
    parameter logic [WIDTH-1:0] MMIO_MASK = WIDTH'(DEF_MMIO_MASK)
) (
    input  logic [WIDTH-1:0] addr,
    output tgt_sel_t         sel,
    output logic             misal
);

    assign misal = |addr[1:0];
    assign sel   = ((addr & MMIO_MASK) == MMIO_BASE) ? TGT_MMIO : TGT_RAM;

endmodule

// File: rtl/data_bus_demux.sv
// Single-outstanding load/store demux: RAM (target 0) vs MMIO (target 1),
// with misalignment and response-timeout error reporting.
module data_bus_demux
    import bus_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] MMIO_BASE = WIDTH'(DEF_MMIO_BASE),
    parameter logic [WIDTH-1:0] MMIO_MASK = WIDTH'(DEF_MMIO_MASK),
    parameter int               TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic             req_we,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             t0_valid,
    input  logic             t0_ready,
    output logic [WIDTH-1:0] t0_addr,
    output logic [WIDTH-1:0] t0_wdata,
    output logic             t0_we,
    input  logic             t0_rsp_valid,
    input  logic [WIDTH-1:0] t0_rsp_rdata,
    output logic             t1_valid,
    input  logic             t1_ready,
    output logic [WIDTH-1:0] t1_addr,
    output logic [WIDTH-1:0] t1_wdata,
    output logic             t1_we,
    input  logic             t1_rsp_valid,
    input  logic [WIDTH-1:0] t1_rsp_rdata
);

    localparam tmo_cnt_t TMO_LIM = tmo_cnt_t'(TIMEOUT);

    demux_state_t     state, state_d;
    tgt_sel_t         sel_q, dec_sel;
    logic             dec_misal;
    logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic             we_q, err_q;
    tmo_cnt_t         cnt;
    logic             accept, capture, tmo;
    logic             sel_ready, sel_rsp_valid;
    logic [WIDTH-1:0] sel_rdata;

    bus_addr_decode #(
        .WIDTH     (WIDTH),
        .MMIO_BASE (MMIO_BASE),
        .MMIO_MASK (MMIO_MASK)
    ) u_dec (
        .addr  (req_addr),
        .sel   (dec_sel),
        .misal (dec_misal)
    );

    // Only the selected target's handshake/response is ever looked at.
    assign sel_ready     = (sel_q == TGT_MMIO) ? t1_ready     : t0_ready;
    assign sel_rsp_valid = (sel_q == TGT_MMIO) ? t1_rsp_valid : t0_rsp_valid;
    assign sel_rdata     = (sel_q == TGT_MMIO) ? t1_rsp_rdata : t0_rsp_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        capture   = 1'b0;
        tmo       = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        t0_valid  = 1'b0;
        t1_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = dec_misal ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                t0_valid = (sel_q == TGT_RAM);
                t1_valid = (sel_q == TGT_MMIO);
                if (sel_ready) begin
                    if (sel_rsp_valid) begin
                        capture = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (sel_rsp_valid) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (cnt == TMO_LIM) begin
                    tmo     = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= TGT_RAM;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                we_q    <= req_we;
                sel_q   <= dec_sel;
                err_q   <= dec_misal;
                cnt     <= '0;
                if (dec_misal) rdata_q <= '0;
            end
            if (state == WAIT) cnt <= cnt + 1'b1;
            // Stores always report zero data, whatever the target drives.
            if (capture) rdata_q <= we_q ? '0 : sel_rdata;
            if (tmo) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign t0_addr   = addr_q;
    assign t0_wdata  = wdata_q;
    assign t0_we     = we_q;
    assign t1_addr   = addr_q;
    assign t1_wdata  = wdata_q;
    assign t1_we     = we_q;

endmodule

// File: tb/tb_data_bus_demux.sv
// Directed bench for data_bus_demux with a response scoreboard.
module tb_data_bus_demux;

    localparam int TMO = 255;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        t0_valid, t0_we, t1_valid, t1_we;
    logic [31:0] t0_addr, t0_wdata, t1_addr, t1_wdata;
    logic        t0_ready = 1'b0, t0_rsp_valid = 1'b0;
    logic        t1_ready = 1'b0, t1_rsp_valid = 1'b0;
    logic [31:0] t0_rsp_rdata = '0, t1_rsp_rdata = '0;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    data_bus_demux #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .t0_valid(t0_valid), .t0_ready(t0_ready), .t0_addr(t0_addr),
        .t0_wdata(t0_wdata), .t0_we(t0_we),
        .t0_rsp_valid(t0_rsp_valid), .t0_rsp_rdata(t0_rsp_rdata),
        .t1_valid(t1_valid), .t1_ready(t1_ready), .t1_addr(t1_addr),
        .t1_wdata(t1_wdata), .t1_we(t1_we),
        .t1_rsp_valid(t1_rsp_valid), .t1_rsp_rdata(t1_rsp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any response pulse seen there.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (rsp_valid === 1'b1) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL rsp_unexpected: observed rdata=%h err=%b expected no response", rsp_rdata, rsp_err);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_rdata", rsp_rdata, e.rdata);
                chk("sb_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = wd;
        req_we    = we;
        cyc();
        req_valid = 1'b0;
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_t0_valid", {31'd0, t0_valid}, 32'd0);
        chk("rst_t1_valid", {31'd0, t1_valid}, 32'd0);
        chk("rst_t0_addr", t0_addr, 32'd0);
        chk("rst_t1_wdata", t1_wdata, 32'd0);
        chk("rst_t1_we", {31'd0, t1_we}, 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: RAM load, minimum latency
        send(32'h0000_0040, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        chk("l1_t0_valid", {31'd0, t0_valid}, 32'd1);
        chk("l1_t1_valid", {31'd0, t1_valid}, 32'd0);
        chk("l1_t0_addr", t0_addr, 32'h0000_0040);
        chk("l1_t0_we", {31'd0, t0_we}, 32'd0);
        chk("l1_req_ready", {31'd0, req_ready}, 32'd0);
        t0_ready = 1'b1; t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'hDEAD_BEEF;
        cyc();
        t0_ready = 1'b0; t0_rsp_valid = 1'b0; t0_rsp_rdata = 32'h0;
        chk("l1_rsp_valid_c2", {31'd0, rsp_valid}, 32'd1);
        chk("l1_t1_valid_c2", {31'd0, t1_valid}, 32'd0);
        cyc();
        chk("l1_rsp_single", {31'd0, rsp_valid}, 32'd0);
        chk("l1_rdata_held", rsp_rdata, 32'hDEAD_BEEF);

        // misaligned load: error on cycle 1, no target access
        send(32'h0000_0042, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("mis_rsp_valid_c1", {31'd0, rsp_valid}, 32'd1);
        chk("mis_t0_valid", {31'd0, t0_valid}, 32'd0);
        chk("mis_t1_valid", {31'd0, t1_valid}, 32'd0);
        cyc();
        chk("mis_rsp_single", {31'd0, rsp_valid}, 32'd0);

        // 2: MMIO store, ready after 3 cycles, response 2 cycles later
        send(32'h1000_0008, 32'h0000_0055, 1'b1, 32'h0, 1'b0);
        chk("st_t1_addr", t1_addr, 32'h1000_0008);
        chk("st_t1_wdata", t1_wdata, 32'h0000_0055);
        chk("st_t1_we", {31'd0, t1_we}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("st_t1_valid_hold", {31'd0, t1_valid}, 32'd1);
            chk("st_t0_valid", {31'd0, t0_valid}, 32'd0);
            chk("st_req_ready", {31'd0, req_ready}, 32'd0);
            cyc();
        end
        t1_ready = 1'b1;
        cyc();
        t1_ready = 1'b0;
        chk("st_wait_t1_valid", {31'd0, t1_valid}, 32'd0);
        chk("st_wait_req_ready", {31'd0, req_ready}, 32'd0);
        cyc();
        chk("st_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
        t1_rsp_valid = 1'b1; t1_rsp_rdata = 32'hABCD_1234;
        cyc();
        t1_rsp_valid = 1'b0; t1_rsp_rdata = 32'h0;
        chk("st_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("st_resp_req_ready", {31'd0, req_ready}, 32'd0);
        cyc();

        // timeout on MMIO load
        send(32'h1000_0000, 32'h0, 1'b0, 32'h0, 1'b1);
        t1_ready = 1'b1;
        cyc();
        t1_ready = 1'b0;
        for (int k = 0; k <= TMO; k++) begin
            chk("tmo_no_rsp_early", {31'd0, rsp_valid}, 32'd0);
            cyc();
        end
        chk("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        cyc();
        t1_rsp_valid = 1'b1; t1_rsp_rdata = 32'h0000_0077;
        cyc();
        t1_rsp_valid = 1'b0;
        chk("tmo_late_ignored", {31'd0, rsp_valid}, 32'd0);
        cyc();
        chk("tmo_late_ignored2", {31'd0, rsp_valid}, 32'd0);

        // stray t0 response while t1 is waiting
        send(32'h1000_0010, 32'h0, 1'b0, 32'h1111_2222, 1'b0);
        t1_ready = 1'b1;
        cyc();
        t1_ready = 1'b0;
        t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'hBAD0_BAD0;
        cyc();
        t0_rsp_valid = 1'b0;
        chk("stray_no_rsp", {31'd0, rsp_valid}, 32'd0);
        t1_rsp_valid = 1'b1; t1_rsp_rdata = 32'h1111_2222;
        cyc();
        t1_rsp_valid = 1'b0;
        chk("stray_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        cyc();

        // reset while in WAIT
        begin
            exp_t dropped;
            send(32'h0000_0080, 32'h0, 1'b0, 32'h0, 1'b0);
            t0_ready = 1'b1;
            cyc();
            t0_ready = 1'b0;
            cyc();
            rst_n = 1'b0;
            #1;
            dropped = sb.pop_back();
            chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
            chk("rstw_t0_valid", {31'd0, t0_valid}, 32'd0);
            chk("rstw_t1_valid", {31'd0, t1_valid}, 32'd0);
            chk("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            cyc();
            rst_n = 1'b1;
            t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'hCAFE_0000;
            cyc();
            t0_rsp_valid = 1'b0;
            chk("rstw_late_ignored", {31'd0, rsp_valid}, 32'd0);
            cyc();
            chk("rstw_late_ignored2", {31'd0, rsp_valid}, 32'd0);
        end
        send(32'h0000_0100, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b0);
        chk("post_t0_valid", {31'd0, t0_valid}, 32'd1);
        t0_ready = 1'b1; t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'h0BAD_F00D;
        cyc();
        t0_ready = 1'b0; t0_rsp_valid = 1'b0;
        chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        cyc();

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
